seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Parametrised multiplexed seven-segment display driver. It is the successor to the fixed four-digit `Display` driver. It scans `NUM_DIGITS` common-anode digits at a programmable refresh rate and decodes 4-bit hex values with per-digit decimal points and blanking. A load strobe captures all digit data atomically, so a value is never shown half-updated. It sits between the vending-machine controller (price, credit and change values) and the board's anode/cathode pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned. Legal range 1..8.
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit. Minimum 2.
- `IDX_W`, `$clog2(NUM_DIGITS)` (min 1): width of the internal scan index. Local, not overridable.

- `clk`  in  1  system clock. Everything is on the rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `load`  in  1  capture strobe for `digits`, `dp` and `blank`.
- `digits`  in  4*NUM_DIGITS  hex value of digit i at `[4i+3:4i]`. Digit 0 is the rightmost.
- `dp`  in  NUM_DIGITS  decimal point request for each digit, active-high.
- `blank`  in  NUM_DIGITS  forces digit i dark, active-high.
- `an`  out  NUM_DIGITS  anode enables, active-low.
- `ca`  out  7  cathodes, active-low. `ca[0]`=a … `ca[6]`=g.
- `dp_n`  out  1  decimal point cathode, active-low.
- `frame_tick`  out  1  one-cycle pulse each time a full scan completes.

## Operation
- **Shadow registers.** Shadow registers hold `digits`, `dp` and `blank`.
  - On a rising edge with `load`=1 (and `clr`=0) they take the inputs.
  - Otherwise they hold their value.
  - Inputs are ignored while `load`=0.
- **Prescaler.** Counts 0..`REFRESH_DIV`-1.
  - At terminal count it wraps to 0 and advances the scan index.
  - The scan index runs 0,1,…,`NUM_DIGITS`-1,0.
- **Scan states.** One state per digit, implemented as the index counter.
  - Transition only at prescaler terminal count.
  - No other transitions.
- **Output register.** Loaded every cycle from the current index and the current shadow registers.
  - `an` = all ones except bit[idx]=0. If `blank[idx]`=1 (or the digit is LZB-blanked), `an` = all ones for that slot. Slot duration is unchanged.
  - `ca` = hex decode of shadow digit[idx]. Patterns in `ca[6:0]` order:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - `ca` = 1111111 when the digit is blanked.
  - `dp_n` = ~`dp[idx]`. Forced to 1 when the digit is blanked.
- **Frame tick.** `frame_tick` is registered. It is 1 for exactly the one cycle in which outputs first show digit 0 after digit `NUM_DIGITS`-1.
- **Single-digit build.** With `NUM_DIGITS`=1 the index stays 0 and `frame_tick` pulses every `REFRESH_DIV` cycles.

## Timing
- **Reset values (`clr`=1 at an edge).**
  - Prescaler = 0, index = 0, shadows = 0.
  - `an` = all ones, `ca` = 1111111, `dp_n` = 1, `frame_tick` = 0.
- **First edge after `clr` falls.** `an` = ~1 (digit 0 on), `ca` = 1000000 (shows "0").
- **Digit change latency.** `an`/`ca` change one cycle after the prescaler wraps. Every digit is lit for exactly `REFRESH_DIV` cycles.
- **Load latency.** A change captured by `load` at edge N appears on the outputs at edge N+1, provided that digit is in its slot.
- **Simultaneous events.**
  - `clr` with `load`: `clr` wins and shadows are zeroed.
  - `load` at a prescaler wrap: the new data and the new index both take effect at edge N+1.
- **Reset mid-scan.** Outputs go dark in the reset cycle. Scanning restarts from digit 0 with a full-length slot.

## Configuration
- **`SEGDISP_LZB_EN` defined:** leading-zero blanking.
  - Starting from digit `NUM_DIGITS`-1 and moving downward, each digit whose shadow value is 0 is blanked until the first nonzero digit.
  - Digit 0 is never LZB-blanked.
  - `dp[i]`=1 stops blanking at digit i and at all digits below it.
  - The explicit `blank` mask still applies on top.
- **Not defined:** all digits are shown unless `blank` is set. Value 0 displays as 1000000.

## Test plan
- **Reset.** Bench `REFRESH_DIV`=4, `NUM_DIGITS`=4. Hold `clr` 3 cycles → `an`=1111, `ca`=1111111, `dp_n`=1. One cycle after `clr` falls → `an`=1110, `ca`=1000000.
- **Scan order.** Load `digits`=16'hA3A5 → `an` steps 1110,1101,1011,0111 with 4 cycles each. `ca` steps 0010010, 0001000, 0110000, 0001000. `frame_tick` pulses once each time `an` returns to 1110.
- **Atomic load.** Change the `digits` input without asserting `load` → no output change. Pulse `load` mid-slot → the current slot's `ca` updates on the next edge.
- **Blank and decimal point.** `blank`=0100, `dp`=0001 → slot 2 shows `an`=1111, `ca`=1111111. Slot 0 shows `dp_n`=0. All other slots show `dp_n`=1.
- **Reset mid-scan.** Assert `clr` during the slot-2 prescaler count of 2 → outputs are dark next edge, and the scan restarts at digit 0 with a full 4-cycle slot.
- **`SEGDISP_LZB_EN` build.** `digits`=16'h0050 → slots 3 and 2 are dark, slot 1 shows 0010010, slot 0 shows 1000000. With `dp`=1000, no digit is LZB-blanked.

Source files
------------

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode seven-segment scanner with atomic load shadows.
// Optional leading-zero blanking is enabled by defining SEGDISP_LZB_EN.
module seg_display_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              ca,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LastPre = PRE_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              ca_q, ca_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_tick_q;
  logic                    tc;
  logic                    dark;
  logic [3:0]              cur_val;
  logic [NUM_DIGITS-1:0]   lzb;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tc = (pre_q == LastPre);

  always_comb begin
    pre_d  = tc ? '0 : pre_q + 1'b1;
    idx_d  = idx_q;
    if (tc) idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    wrap_d = tc && (idx_q == LastIdx);
  end

  // Leading-zero run from the top digit; a set dp or nonzero value ends it.
  always_comb begin
    lzb = '0;
`ifdef SEGDISP_LZB_EN
    begin
      logic run;
      run = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
        run    = run && (digits_q[4*i +: 4] == 4'h0) && !dp_q[i];
        lzb[i] = run;
      end
    end
`endif
  end

  always_comb begin
    cur_val = digits_q[4*int'(idx_q) +: 4];
    dark    = blank_q[idx_q] | lzb[idx_q];
    an_d    = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    ca_d    = dark ? 7'b1111111 : seg7(cur_val);
    dp_n_d  = dark | ~dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      digits_q     <= '0;
      dp_q         <= '0;
      blank_q      <= '0;
      pre_q        <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      an_q         <= '1;
      ca_q         <= 7'b1111111;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      if (load) begin
        digits_q <= digits;
        dp_q     <= dp;
        blank_q  <= blank;
      end
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      an_q         <= an_d;
      ca_q         <= ca_d;
      dp_n_q       <= dp_n_d;
      // Outputs show the wrapped-to digit 0 one edge after the wrap.
      frame_tick_q <= wrap_q;
    end
  end

  assign an         = an_q;
  assign ca         = ca_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan (NUM_DIGITS=4, REFRESH_DIV=4).
// Compile with SEGDISP_LZB_EN defined to exercise leading-zero blanking.
module tb_seg_display_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        dp_n;
  logic        frame_tick;

  seg_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .clr(clr), .load(load), .digits(digits), .dp(dp), .blank(blank),
    .an(an), .ca(ca), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [3:0] dpv;
    logic [6:0] exp_ca;
    logic       exp_dpn;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: shadows plus cycles elapsed since the last reset edge.
  logic [6:0] seg_tab [16];
  logic [3:0] m_dig [4];
  logic [3:0] m_dp, m_blank;
  int         c = 0;
  bit         m_valid = 0;
  int         shown_slot = -1;

  function automatic bit lzb_blanked(int i);
`ifdef SEGDISP_LZB_EN
    if (i == 0) return 1'b0;
    for (int j = i; j < ND; j++)
      if (m_dig[j] != 4'h0 || m_dp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    logic [3:0] x_an;
    logic [6:0] x_ca;
    logic       x_dpn, x_ft;
    int         slot;
    slot = (c / RD) % ND;
    x_an = 4'hF; x_ca = 7'h7F; x_dpn = 1'b1; x_ft = 1'b0;
    if (!clr) begin
      if (!(m_blank[slot] || lzb_blanked(slot))) begin
        x_an[slot] = 1'b0;
        x_ca       = seg_tab[m_dig[slot]];
        x_dpn      = ~m_dp[slot];
      end
      x_ft = (c > 0) && (c % (RD * ND) == 0);
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("an", 16'(an), 16'(x_an));
      check("ca", 16'(ca), 16'(x_ca));
      check("dp_n", 16'(dp_n), 16'(x_dpn));
      check("frame_tick", 16'(frame_tick), 16'(x_ft));
    end
    if (clr) begin
      c = 0; m_valid = 1; shown_slot = -1;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
      m_dp = '0; m_blank = '0;
    end else begin
      shown_slot = slot;
      c++;
      if (load) begin
        for (int i = 0; i < ND; i++) m_dig[i] = digits[4*i +: 4];
        m_dp = dp; m_blank = blank;
      end
    end
  endtask

  initial begin
    vec_t       tab [16];
    logic [3:0] exp_an_t [4];
    logic [6:0] exp_ca_t [4];
    logic [6:0] new_ca_t [4];
    int         ft_cnt;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    tab[0]  = '{4'h0, 4'hF, 7'b1000000, 1'b0};
    tab[1]  = '{4'h1, 4'hF, 7'b1111001, 1'b0};
    tab[2]  = '{4'h2, 4'h0, 7'b0100100, 1'b1};
    tab[3]  = '{4'h3, 4'hF, 7'b0110000, 1'b0};
    tab[4]  = '{4'h4, 4'h0, 7'b0011001, 1'b1};
    tab[5]  = '{4'h5, 4'hF, 7'b0010010, 1'b0};
    tab[6]  = '{4'h6, 4'h0, 7'b0000010, 1'b1};
    tab[7]  = '{4'h7, 4'hF, 7'b1111000, 1'b0};
    tab[8]  = '{4'h8, 4'h0, 7'b0000000, 1'b1};
    tab[9]  = '{4'h9, 4'hF, 7'b0010000, 1'b0};
    tab[10] = '{4'hA, 4'h0, 7'b0001000, 1'b1};
    tab[11] = '{4'hB, 4'hF, 7'b0000011, 1'b0};
    tab[12] = '{4'hC, 4'h0, 7'b1000110, 1'b1};
    tab[13] = '{4'hD, 4'hF, 7'b0100001, 1'b0};
    tab[14] = '{4'hE, 4'h0, 7'b0000110, 1'b1};
    tab[15] = '{4'hF, 4'hF, 7'b0001110, 1'b0};
    exp_an_t = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_ca_t = '{7'b0010010, 7'b0001000, 7'b0110000, 7'b0001000};
    new_ca_t = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_dp = '0; m_blank = '0;

    // Reset, then first edge after release shows "0" on digit 0.
    clr = 1'b1;
    repeat (3) step();
    check("reset_an", 16'(an), 16'hF);
    check("reset_ca", 16'(ca), 16'h7F);
    check("reset_dp_n", 16'(dp_n), 16'h1);
    clr = 1'b0;
    step();
    check("first_an", 16'(an), 16'(4'b1110));
    check("first_ca", 16'(ca), 16'(7'b1000000));

    // Scan order and frame tick.
    digits = 16'hA3A5; load = 1'b1;
    step();
    load = 1'b0;
    ft_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (frame_tick === 1'b1) ft_cnt++;
      check("scan_an", 16'(an), 16'(exp_an_t[shown_slot]));
      check("scan_ca", 16'(ca), 16'(exp_ca_t[shown_slot]));
    end
    check("frame_tick_count", 16'(ft_cnt), 16'd2);

    // Inputs without load are ignored; a mid-slot load shows on the next edge.
    digits = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      step();
      check("noload_ca", 16'(ca), 16'(exp_ca_t[shown_slot]));
    end
    while (c % RD != 1) step();
    load = 1'b1;
    step();
    load = 1'b0;
    check("loadedge_ca", 16'(ca), 16'(exp_ca_t[shown_slot]));
    step();
    check("loadnext_ca", 16'(ca), 16'(new_ca_t[shown_slot]));

    // Blank and decimal point.
    blank = 4'b0100; dp = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (shown_slot == 2) begin
        check("blank_an", 16'(an), 16'hF);
        check("blank_ca", 16'(ca), 16'h7F);
      end
      check("dp_slot", 16'(dp_n), (shown_slot == 0) ? 16'h0 : 16'h1);
    end

    // Reset mid-scan at slot 2, prescaler 2.
    while (c % (RD * ND) != 10) step();
    clr = 1'b1;
    step();
    check("midreset_an", 16'(an), 16'hF);
    check("midreset_ca", 16'(ca), 16'h7F);
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("restart_an0", 16'(an), 16'(4'b1110));
    end
    step();
    check("restart_an1", 16'(an), 16'(4'b1101));

    // Leading zeros.
    digits = 16'h0050; dp = '0; blank = '0; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
`ifdef SEGDISP_LZB_EN
      if (shown_slot >= 2) check("lzb_dark_an", 16'(an), 16'hF);
`else
      if (shown_slot == 3) check("nolzb_zero_ca", 16'(ca), 16'(7'b1000000));
`endif
      if (shown_slot == 1) check("lzb_d1_ca", 16'(ca), 16'(7'b0010010));
      if (shown_slot == 0) check("lzb_d0_ca", 16'(ca), 16'(7'b1000000));
    end
    dp = 4'b1000; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      check("lzb_dp_lit", 16'(an == 4'hF), 16'h0);
    end

    // Decode table.
    dp = '0;
    for (int k = 0; k < 16; k++) begin
      digits = {4{tab[k].v}}; dp = tab[k].dpv; blank = '0; load = 1'b1;
      step();
      load = 1'b0;
      step();
      check("tab_ca", 16'(ca), 16'(tab[k].exp_ca));
      check("tab_dp_n", 16'(dp_n), 16'(tab[k].exp_dpn));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      clr  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < ND; i++)
        digits[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
